mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
Main control unit for the multicycle ARM datapath. It holds the instruction-sequencing FSM and the condition-flag register, and it evaluates condition codes. It drives every enable and mux select in the shared datapath (PC, instruction register, memory, register file, ALU) one state per cycle. It also counts retired instructions for performance monitoring.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
Op  in  2  Instr[27:26]
Funct  in  6  Instr[25:20]
Rd  in  4  Instr[15:12]
Cond  in  4  Instr[31:28]
ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle
PCWrite  out  1  PC register enable
MemWrite  out  1  data memory write enable
RegWrite  out  1  register file write enable
IRWrite  out  1  instruction register enable
AdrSrc  out  1  memory address select: 0=PC, 1=ALUResult
ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  2  ALU A select: 00=RA1 data, 01=PC
ALUSrcB  out  2  ALU B select: 00=RA2 data, 01=ExtImm, 10=constant 4
ALUControl  out  2  ALU operation: 00=ADD, 01=SUB, 10=AND, 11=ORR
Undef  out  1  pulses for one cycle in DECODE when Op=11
RetiredCnt  out  CNT_W  number of instructions completed

Behaviour:
- Timing: state register and flags register are registered; all outputs are combinational from the state and the inputs.
- Reset (synchronous): state=FETCH, Flags=0000, RetiredCnt=0.
  - While reset=1, PCWrite, MemWrite, RegWrite, IRWrite and Undef are forced to 0. Mux selects take their FETCH values.
  - Reset asserted mid-instruction aborts it: no write occurs in that cycle, and fetch restarts on the next cycle.
- States and transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR if Op=01; EXECUTER if Op=00 and Funct[5]=0; EXECUTEI if Op=00 and Funct[5]=1; BRANCH if Op=10; FETCH if Op=11 (Undef=1).
  - MEMADR -> MEMREAD if Funct[0]=1, else MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER and EXECUTEI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
- Per-state outputs (signals not listed are 0 / 00):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, NextPC=1.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, MemW=1.
  - EXECUTER: ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode:
  - ALUOp=0 gives ADD.
  - ALUOp=1 decodes Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, NoWrite). Any other code gives ADD.
  - ALUWB of a CMP suppresses RegW.
- Flags:
  - FlagW[1] (N,Z) = ALUOp & Funct[0].
  - FlagW[0] (C,V) = ALUOp & Funct[0] & op in {ADD, SUB, CMP}.
  - In EXECUTER/EXECUTEI, on the clock edge: if CondEx, update N,Z when FlagW[1] and C,V when FlagW[0], from ALUFlags.
- CondEx: standard ARM evaluation of Cond against the stored flags.
  - 0000 EQ through 1101 LE per the architecture.
  - 1110 AL is always 1.
  - 1111 is 0.
- Write gating:
  - PCS = Branch | (RegW & Rd==1111).
  - PCWrite = NextPC | (PCS & CondEx).
  - RegWrite = RegW & CondEx & ~(Rd==1111).
  - MemWrite = MemW & CondEx.
  - A failed condition still walks all states but performs no architectural write.
- RetiredCnt: increments by 1 on any transition into FETCH from a state other than FETCH or reset, including the DECODE exit on Op=11. It wraps from all-ones to 0.
- Cycle counts: LDR 5, STR 4, data-processing 4, B 3, undefined 2.

Test Plan:
- Reset held 2 cycles, then released with Op=00, Funct=001000 (ADD reg), Cond=1110 -> state sequence F,D,ER,AW,F. IRWrite=1 only in the first cycle. RegWrite=1 in AW with ResultSrc=00. RetiredCnt=1.
- LDR (Op=01, Funct=011001) then STR (Funct=011000), Cond=1110 -> 5 then 4 cycles. MemWB has ResultSrc=01, RegWrite=1. MEMWRITE has AdrSrc=1, MemWrite=1. RetiredCnt=2.
- SUBS with ALUFlags=0100 (Z set), then B with Cond=0000 (EQ) -> BRANCH has PCWrite=1. Repeat with ALUFlags=0000 and the second B: PCWrite=0 in BRANCH, but RetiredCnt still increments.
- CMP (Funct=010101) with Cond=1110 -> RegWrite=0 in ALUWB and flags updated. A following ADDEQ (Cond=0000) with Z=0 -> RegWrite=0 and flags unchanged.
- ADD with Rd=1111 -> RegWrite=0 and PCWrite=1 in ALUWB. Op=11 -> Undef=1 in DECODE, then FETCH next cycle.
- Assert reset in the MEMWRITE cycle -> MemWrite=0 that cycle. Next state is FETCH, Flags=0, RetiredCnt=0.

Source files
------------

// File: rtl/mc_controller.sv
// mc_controller: main control unit for the multicycle ARM datapath.
// Holds the instruction-sequencing FSM, the {N,Z,C,V} condition-flag register
// and the retired-instruction counter. Every datapath enable and mux select is
// produced combinationally from the current state and the instruction fields.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   Op, Funct, Rd, Cond   instruction fields Instr[27:26], [25:20], [15:12], [31:28]
//   ALUFlags              {N,Z,C,V} from the ALU in the current cycle
//   PCWrite, MemWrite,
//   RegWrite, IRWrite     architectural write enables (condition-gated)
//   AdrSrc, ResultSrc,
//   ALUSrcA, ALUSrcB      datapath mux selects
//   ALUControl            00=ADD 01=SUB 10=AND 11=ORR
//   Undef                 one-cycle pulse in DECODE for Op=11
//   RetiredCnt            count of completed instructions (wraps)
module mc_controller #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       Op,
   input  logic [5:0]       Funct,
   input  logic [3:0]       Rd,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   output logic             PCWrite,
   output logic             MemWrite,
   output logic             RegWrite,
   output logic             IRWrite,
   output logic             AdrSrc,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUControl,
   output logic             Undef,
   output logic [CNT_W-1:0] RetiredCnt
);

   localparam logic [3:0] FETCH    = 4'd0;
   localparam logic [3:0] DECODE   = 4'd1;
   localparam logic [3:0] MEMADR   = 4'd2;
   localparam logic [3:0] MEMREAD  = 4'd3;
   localparam logic [3:0] MEMWB    = 4'd4;
   localparam logic [3:0] MEMWRITE = 4'd5;
   localparam logic [3:0] EXECUTER = 4'd6;
   localparam logic [3:0] EXECUTEI = 4'd7;
   localparam logic [3:0] ALUWB    = 4'd8;
   localparam logic [3:0] BRANCH   = 4'd9;

   // ARM condition-code evaluation against stored flags {N,Z,C,V}.
   function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
      logic n, z, c, v;
      n = flags[3];
      z = flags[2];
      c = flags[1];
      v = flags[0];
      case (cond)
         4'b0000: cond_check = z;
         4'b0001: cond_check = ~z;
         4'b0010: cond_check = c;
         4'b0011: cond_check = ~c;
         4'b0100: cond_check = n;
         4'b0101: cond_check = ~n;
         4'b0110: cond_check = v;
         4'b0111: cond_check = ~v;
         4'b1000: cond_check = c & ~z;
         4'b1001: cond_check = ~c | z;
         4'b1010: cond_check = (n == v);
         4'b1011: cond_check = (n != v);
         4'b1100: cond_check = ~z & (n == v);
         4'b1101: cond_check = z | (n != v);
         4'b1110: cond_check = 1'b1;
         default: cond_check = 1'b0;
      endcase
   endfunction

   logic [3:0]       state_r;
   logic [3:0]       next_state_s;
   logic [3:0]       eff_state_s;
   logic [3:0]       flags_r;
   logic [CNT_W-1:0] cnt_r;
   logic             next_pc_s;
   logic             reg_w_s;
   logic             mem_w_s;
   logic             branch_s;
   logic             alu_op_s;
   logic             ir_w_s;
   logic             undef_s;
   logic             is_cmp_s;
   logic             is_arith_s;
   logic             cond_ex_s;
   logic [1:0]       flag_w_s;
   logic             rd_pc_s;
   logic             pcs_s;

   // During reset the selects behave as in FETCH.
   assign eff_state_s = reset ? FETCH : state_r;

   // Next-state logic of the instruction sequencer.
   always_comb begin
      next_state_s = FETCH;
      case (state_r)
         FETCH:    next_state_s = DECODE;
         DECODE: begin
            case (Op)
               2'b00:   next_state_s = Funct[5] ? EXECUTEI : EXECUTER;
               2'b01:   next_state_s = MEMADR;
               2'b10:   next_state_s = BRANCH;
               default: next_state_s = FETCH;
            endcase
         end
         MEMADR:   next_state_s = Funct[0] ? MEMREAD : MEMWRITE;
         MEMREAD:  next_state_s = MEMWB;
         MEMWB:    next_state_s = FETCH;
         MEMWRITE: next_state_s = FETCH;
         EXECUTER: next_state_s = ALUWB;
         EXECUTEI: next_state_s = ALUWB;
         ALUWB:    next_state_s = FETCH;
         BRANCH:   next_state_s = FETCH;
         default:  next_state_s = FETCH;
      endcase
   end

   // Per-state raw controls and mux selects.
   always_comb begin
      next_pc_s = 1'b0;
      reg_w_s   = 1'b0;
      mem_w_s   = 1'b0;
      branch_s  = 1'b0;
      alu_op_s  = 1'b0;
      ir_w_s    = 1'b0;
      undef_s   = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      case (eff_state_s)
         FETCH: begin
            ir_w_s = 1'b1; ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; next_pc_s = 1'b1;
         end
         DECODE: begin
            ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; undef_s = (Op == 2'b11);
         end
         MEMADR:   ALUSrcB = 2'b01;
         MEMREAD:  AdrSrc = 1'b1;
         MEMWB: begin
            ResultSrc = 2'b01; reg_w_s = 1'b1;
         end
         MEMWRITE: begin
            AdrSrc = 1'b1; mem_w_s = 1'b1;
         end
         EXECUTER: alu_op_s = 1'b1;
         EXECUTEI: begin
            ALUSrcB = 2'b01; alu_op_s = 1'b1;
         end
         ALUWB:    reg_w_s = ~is_cmp_s;   // CMP only sets flags
         BRANCH: begin
            ALUSrcB = 2'b01; ResultSrc = 2'b10; branch_s = 1'b1;
         end
         default: begin
            next_pc_s = 1'b0;
         end
      endcase
   end

   // ALU operation decode from Funct[4:1].
   always_comb begin
      ALUControl = 2'b00;
      is_cmp_s   = 1'b0;
      is_arith_s = 1'b0;
      case (Funct[4:1])
         4'b0100: begin ALUControl = 2'b00; is_arith_s = 1'b1; end
         4'b0010: begin ALUControl = 2'b01; is_arith_s = 1'b1; end
         4'b0000: ALUControl = 2'b10;
         4'b1100: ALUControl = 2'b11;
         4'b1010: begin ALUControl = 2'b01; is_arith_s = 1'b1; is_cmp_s = 1'b1; end
         default: ALUControl = 2'b00;
      endcase
      if (!alu_op_s) begin
         ALUControl = 2'b00;
      end else begin
         ALUControl = ALUControl;
      end
   end

   assign flag_w_s[1] = alu_op_s & Funct[0];
   assign flag_w_s[0] = alu_op_s & Funct[0] & is_arith_s;
   assign cond_ex_s   = cond_check(Cond, flags_r);
   assign rd_pc_s     = (Rd == 4'b1111);
   assign pcs_s       = branch_s | (reg_w_s & rd_pc_s);

   // Architectural writes are suppressed while reset is asserted.
   assign PCWrite    = ~reset & (next_pc_s | (pcs_s & cond_ex_s));
   assign RegWrite   = ~reset & reg_w_s & cond_ex_s & ~rd_pc_s;
   assign MemWrite   = ~reset & mem_w_s & cond_ex_s;
   assign IRWrite    = ~reset & ir_w_s;
   assign Undef      = ~reset & undef_s;
   assign RetiredCnt = cnt_r;

   // State, flags and retired-instruction counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= FETCH;
         flags_r <= 4'b0000;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= next_state_s;
         if (((state_r == EXECUTER) || (state_r == EXECUTEI)) && cond_ex_s) begin
            if (flag_w_s[1]) flags_r[3:2] <= ALUFlags[3:2];
            if (flag_w_s[0]) flags_r[1:0] <= ALUFlags[1:0];
         end
         // Any return to FETCH completes an instruction, undefined ones included.
         if ((next_state_s == FETCH) && (state_r != FETCH)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller. A small reference model pushes the
// expected per-cycle control word of each instruction into a queue; the
// queue is popped and compared every cycle on the falling clock edge.
module tb_mc_controller;

   localparam int CW = 4;   // narrow counter so the wrap is exercised

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    Op;
   logic [5:0]    Funct;
   logic [3:0]    Rd;
   logic [3:0]    Cond;
   logic [3:0]    ALUFlags;
   logic          PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, Undef;
   logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB, ALUControl;
   logic [CW-1:0] RetiredCnt;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [13:0]   exp_q[$];
   string         tag_q[$];
   logic [3:0]    m_flags;
   logic [CW-1:0] m_cnt;

   mc_controller #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
      .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUControl(ALUControl), .Undef(Undef), .RetiredCnt(RetiredCnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,Undef}
   function automatic logic [13:0] cw(input logic pcw, input logic mw, input logic rw,
                                      input logic irw, input logic adr, input logic [1:0] res,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] alu, input logic und);
      cw = {pcw, mw, rw, irw, adr, res, sa, sb, alu, und};
   endfunction

   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      case (c)
         4'h0: cond_ok = f[2];
         4'h1: cond_ok = !f[2];
         4'h2: cond_ok = f[1];
         4'h3: cond_ok = !f[1];
         4'h4: cond_ok = f[3];
         4'h5: cond_ok = !f[3];
         4'h6: cond_ok = f[0];
         4'h7: cond_ok = !f[0];
         4'h8: cond_ok = f[1] && !f[2];
         4'h9: cond_ok = !f[1] || f[2];
         4'hA: cond_ok = f[3] == f[0];
         4'hB: cond_ok = f[3] != f[0];
         4'hC: cond_ok = !f[2] && (f[3] == f[0]);
         4'hD: cond_ok = f[2] || (f[3] != f[0]);
         4'hE: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   endfunction

   function automatic logic [13:0] cur_cw();
      cur_cw = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
                ALUSrcA, ALUSrcB, ALUControl, Undef};
   endfunction

   // Runs one instruction; reset_at >= 0 asserts reset in that cycle of it.
   task automatic run(input string name, input logic [1:0] op, input logic [5:0] fn,
                      input logic [3:0] rd, input logic [3:0] cond, input logic [3:0] af,
                      input int reset_at);
      logic       ce, cmp, arith, pc_rd;
      logic [1:0] aluc;
      int         n;
      Op = op; Funct = fn; Rd = rd; Cond = cond; ALUFlags = af;
      ce    = cond_ok(cond, m_flags);
      pc_rd = (rd == 4'hF);
      cmp   = (fn[4:1] == 4'b1010);
      case (fn[4:1])
         4'b0100: begin aluc = 2'b00; arith = 1'b1; end
         4'b0010: begin aluc = 2'b01; arith = 1'b1; end
         4'b1010: begin aluc = 2'b01; arith = 1'b1; end
         4'b0000: begin aluc = 2'b10; arith = 1'b0; end
         4'b1100: begin aluc = 2'b11; arith = 1'b0; end
         default: begin aluc = 2'b00; arith = 1'b0; end
      endcase
      exp_q.push_back(cw(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0));
      exp_q.push_back(cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 2'b00, op == 2'b11));
      case (op)
         2'b00: begin
            exp_q.push_back(cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
                               fn[5] ? 2'b01 : 2'b00, aluc, 1'b0));
            exp_q.push_back(cw(ce && !cmp && pc_rd, 1'b0, ce && !cmp && !pc_rd, 1'b0, 1'b0,
                               2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
         end
         2'b01: begin
            exp_q.push_back(cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0));
            if (fn[0]) begin
               exp_q.push_back(cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
               exp_q.push_back(cw(ce && pc_rd, 1'b0, ce && !pc_rd, 1'b0, 1'b0,
                                  2'b01, 2'b00, 2'b00, 2'b00, 1'b0));
            end else begin
               exp_q.push_back(cw(1'b0, ce, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
            end
         end
         2'b10: exp_q.push_back(cw(ce, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0));
         default: ;
      endcase
      if (reset_at >= 0) begin
         while (exp_q.size() > reset_at) void'(exp_q.pop_back());
         exp_q.push_back(cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0));
      end
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         tag_q.push_back($sformatf("%s.c%0d", name, i));
      end
      for (int i = 0; i < n; i++) begin
         if (i == reset_at) reset = 1'b1;
         @(negedge clk);
         check(tag_q.pop_front(), 16'(cur_cw()), 16'(exp_q.pop_front()));
         @(posedge clk);
         #1;
      end
      if (reset_at >= 0) begin
         reset   = 1'b0;
         m_flags = 4'b0000;
         m_cnt   = '0;
      end else begin
         if (op == 2'b00 && ce && fn[0]) begin
            m_flags[3:2] = af[3:2];
            if (arith) m_flags[1:0] = af[1:0];
         end
         m_cnt = m_cnt + 1'b1;
      end
      check({name, ".cnt"}, 16'(RetiredCnt), 16'(m_cnt));
   endtask

   initial begin
      reset = 1'b1; Op = 2'b00; Funct = 6'b001000; Rd = 4'h1; Cond = 4'hE; ALUFlags = 4'h0;
      m_flags = 4'b0000;
      m_cnt   = '0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst.ctl", 16'(cur_cw()),
               16'(cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0)));
         check("rst.cnt", 16'(RetiredCnt), 16'd0);
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      //   name     op     funct      rd    cond  aluflags rst
      run("add",   2'b00, 6'b001000, 4'h1, 4'hE, 4'h0, -1);
      run("ldr",   2'b01, 6'b011001, 4'h2, 4'hE, 4'h0, -1);
      run("str",   2'b01, 6'b011000, 4'h2, 4'hE, 4'h0, -1);
      run("subsz", 2'b00, 6'b000101, 4'h3, 4'hE, 4'h4, -1);
      run("beq_t", 2'b10, 6'b100000, 4'h0, 4'h0, 4'h0, -1);
      run("subs0", 2'b00, 6'b000101, 4'h3, 4'hE, 4'h0, -1);
      run("beq_n", 2'b10, 6'b100000, 4'h0, 4'h0, 4'h0, -1);
      run("cmp",   2'b00, 6'b010101, 4'h0, 4'hE, 4'h2, -1);
      run("addeq", 2'b00, 6'b001001, 4'h4, 4'h0, 4'h4, -1);
      run("bcs",   2'b10, 6'b100000, 4'h0, 4'h2, 4'h0, -1);
      run("beq_c", 2'b10, 6'b100000, 4'h0, 4'h0, 4'h0, -1);
      run("orri",  2'b00, 6'b111000, 4'h5, 4'hE, 4'h0, -1);
      run("and",   2'b00, 6'b000000, 4'h6, 4'hE, 4'h0, -1);
      run("addpc", 2'b00, 6'b001000, 4'hF, 4'hE, 4'h0, -1);
      run("undef", 2'b11, 6'b000000, 4'h0, 4'hE, 4'h0, -1);
      run("ldrnv", 2'b01, 6'b011001, 4'h7, 4'hF, 4'h0, -1);
      run("subsz2",2'b00, 6'b000101, 4'h3, 4'hE, 4'h4, -1);
      run("strrst",2'b01, 6'b011000, 4'h2, 4'h0, 4'h0, 3);
      run("beq_r", 2'b10, 6'b100000, 4'h0, 4'h0, 4'h0, -1);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
